ps2_tx_funcmod: RTL and testbench
=================================

Name: ps2_tx_funcmod

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xFF reset, 0xED set-LEDs, 0xF4 enable) to a keyboard or mouse using the PS/2 host request-to-send sequence. It sits beside the PS/2 receive function module and shares the same PS2_CLK/PS2_DAT pins. Both lines are open-drain and are only ever driven low or released.

Parameters:
T100US, 16'd5000, cycles of CLOCK for the 100 us clock-inhibit (50 MHz system clock).
TIMEOUT, 20'd750000, cycles of CLOCK (15 ms) allowed between consecutive device clock falling edges before the transfer aborts.

Ports:
CLOCK  input  1  system clock, all logic on rising edge.
RESET  input  1  asynchronous, active-low reset.
iCall  input  1  start request; sampled only in IDLE.
iData  input  8  command byte; latched on the accepted iCall.
PS2_CLK  inout  1  open-drain: driven 0 or high-Z.
PS2_DAT  inout  1  open-drain: driven 0 or high-Z.
oBusy  output  1  high from the accepted iCall until the cycle after oDone.
oDone  output  1  one-cycle completion pulse.
oErr  output  1  result flag, valid with oDone, held until the next accepted iCall.

Behaviour:
- Reset values: oBusy=0, oDone=0, oErr=0, both pins released (Z). Reset is asynchronous, so asserting it mid-transfer releases both pins and returns to IDLE immediately.
- Input synchronisation:
  - PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser; both reset to 2'b11.
  - isH2L = previous flop 1 and current flop 0; this is the clock falling edge used by the FSM.
- Latch at accept: on accepting iCall, latch iData into the shift register and compute parity P = ~^iData (odd parity).
- FSM states and transitions:
  - IDLE: pins released. iCall=1 → latch, oBusy=1, oErr=0, clear counter, go to INHIBIT.
  - INHIBIT: drive CLK low, count 0..T100US-1. At count T100US-1, also drive DAT low (start bit) and go to RTS.
  - RTS: one cycle with CLK and DAT both low. Next cycle release CLK, keep DAT low, clear the timeout counter, go to SEND.
  - SEND: edge counter k counts device falling edges (isH2L).
    - k=1..8: drive DAT to bit k-1, LSB first (bit 0 → drive low, bit 1 → release).
    - k=9: drive DAT to P.
    - k=10: release DAT (stop bit).
    - k=11: sample the synchronised DAT. 0 = ACK, oErr stays 0; 1 = no ACK, oErr=1. Go to WAIT_IDLE.
  - WAIT_IDLE: pins released. Wait until synchronised CLK=1 and DAT=1 (≤TIMEOUT cycles), then go to DONE.
  - DONE: oDone=1 for one cycle, then IDLE. oBusy drops in the cycle after DONE.
- Data changes only after a falling edge, so DAT is stable while the device samples on the rising edge.
- Timeout:
  - In SEND and WAIT_IDLE the counter is cleared on every isH2L and increments otherwise.
  - Reaching TIMEOUT-1 → release both pins, oErr=1, go to DONE.
- iCall handling: ignored while oBusy=1; no queuing. An iCall held high continuously restarts a new transfer the cycle after DONE.
- Latency: oDone occurs T100US+2 cycles plus device clocking time after iCall.
- A device falling edge that occurs during INHIBIT or RTS is ignored and is not counted.

Test Plan:
- Reset check → both pins Z (read 1 through pull-up), oBusy=0, oDone=0, oErr=0; pulse iCall during reset → no activity.
- iCall with iData=0xF4, device model clocks at 12.5 kHz and ACKs → CLK held low exactly 5000 cycles, DAT low before CLK is released; device samples 0,0,1,0,1,1,1,1, parity 0, stop 1; oDone pulse, oErr=0, oBusy falls one cycle after oDone.
- iData=0xFF → device samples eight 1s and parity 1; iData=0xED → bits 1,0,1,1,0,1,1,1 and parity 1; both end with oErr=0.
- Device clocks all 11 edges but leaves DAT high at the ACK edge → oDone with oErr=1; pins released.
- Device never clocks after RTS → after 750000 cycles both pins released, oDone with oErr=1; a second iCall then completes normally.
- iCall re-asserted at edge 5 with a different byte → ignored, original byte completes. Separately, RESET pulsed low at edge 6 → pins Z immediately, FSM in IDLE, oBusy=0.

Source files
------------

// File: rtl/ps2_tx_funcmod.sv
// PS/2 host-to-device transmitter: sends one command byte using the
// request-to-send sequence. PS2_CLK/PS2_DAT are open-drain and are only
// ever driven low or released.
module ps2_tx_funcmod #(
    parameter logic [15:0] T100US  = 16'd5000,
    parameter logic [19:0] TIMEOUT = 20'd750000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       iCall,
    input  logic [7:0] iData,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       oBusy,
    output logic       oDone,
    output logic       oErr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_WAIT_IDLE,
        ST_DONE
    } state_t;

    localparam logic [19:0] INH_LAST = 20'(T100US) - 20'd1;
    localparam logic [19:0] TO_LAST  = TIMEOUT - 20'd1;

    state_t      state_q;
    logic [19:0] cnt_q;
    logic [3:0]  k_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic        clk_oe_q;
    logic        dat_oe_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [1:0]  clk_sync_q;
    logic [1:0]  dat_sync_q;
    logic        is_h2l;

    // Two-flop synchronisers for the device-driven lines (idle high)
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    assign is_h2l = clk_sync_q[1] & ~clk_sync_q[0];

    // Transfer sequencer; all pin enables and status outputs are registered
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    if (iCall) begin
                        shift_q  <= iData;
                        par_q    <= ~^iData;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b1;
                        state_q  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        dat_oe_q <= 1'b1;
                        state_q  <= ST_RTS;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                ST_RTS: begin
                    clk_oe_q <= 1'b0;
                    cnt_q    <= '0;
                    k_q      <= '0;
                    state_q  <= ST_SEND;
                end
                ST_SEND: begin
                    if (is_h2l) begin
                        // k_q holds the number of edges seen before this one
                        cnt_q <= '0;
                        k_q   <= k_q + 4'd1;
                        if (k_q < 4'd8) begin
                            dat_oe_q <= ~shift_q[0];
                            shift_q  <= {1'b0, shift_q[7:1]};
                        end else if (k_q == 4'd8) begin
                            dat_oe_q <= ~par_q;
                        end else if (k_q == 4'd9) begin
                            dat_oe_q <= 1'b0;
                        end else begin
                            err_q    <= dat_sync_q[1];
                            dat_oe_q <= 1'b0;
                            state_q  <= ST_WAIT_IDLE;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                ST_WAIT_IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    if (clk_sync_q[1] && dat_sync_q[1]) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (is_h2l) begin
                        cnt_q <= '0;
                    end else if (cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;
    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oErr    = err_q;

endmodule

// File: tb/tb_ps2_tx_funcmod.sv
// Bench for ps2_tx_funcmod: a PS/2 device model clocks transfers, a
// scoreboard queue holds expected results, a monitor checks each oDone.
module tb_ps2_tx_funcmod;

    localparam int T100 = 40;
    localparam int TO   = 600;
    localparam int HALF = 20;
    localparam int ACK    = 0;
    localparam int NOACK  = 1;
    localparam int SILENT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       call = 1'b0;
    logic [7:0] data = 8'h00;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_tx_funcmod #(
        .T100US  (16'd40),
        .TIMEOUT (20'd600)
    ) dut (
        .CLOCK   (clk),
        .RESET   (rst_n),
        .iCall   (call),
        .iData   (data),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat),
        .oBusy   (busy),
        .oDone   (done),
        .oErr    (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        logic       err;
        bit         has_frame;
    } exp_t;

    exp_t       expq[$];
    exp_t       cur;
    logic [9:0] cap_frame = '0;
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference frame as the device should see it: 8 data bits LSB first,
    // odd parity, stop bit 1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic [9:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = ((int'(d) / (1 << i)) % 2) == 1;
            ones += int'(f[i]);
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    // Monitor: pops the scoreboard on every completion pulse
    initial begin
        forever begin
            @(negedge clk);
            if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
            prev_done = done;
            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got oDone=1 expected no completion at %0t", $time);
                end else begin
                    cur = expq.pop_front();
                    check("oErr", 32'(err), 32'(cur.err));
                    check("pins_released", 32'({ps2_clk, ps2_dat}), 32'h3);
                    if (cur.has_frame) check("frame", 32'(cap_frame), 32'(model_frame(cur.d)));
                end
            end
        end
    end

    // Device model: observes the request-to-send, then clocks 11 edges
    task automatic device(input int mode, input int poke_k, input logic [7:0] poke_d, input int reset_k);
        int n;
        cap_frame = '0;
        n = 0;
        while (ps2_clk !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk !== 1'b0) begin
            check("inhibit_start", 32'(ps2_clk), 32'd0);
            return;
        end
        n = 1;
        while (n < T100 + 20) begin
            @(negedge clk);
            if (ps2_clk !== 1'b0) break;
            n++;
        end
        total++;
        if (n < T100 || n > T100 + 1) begin
            bad++;
            $display("FAIL inhibit_len: got %0d cycles expected %0d..%0d", n, T100, T100 + 1);
        end
        check("start_bit_at_release", 32'(ps2_dat), 32'd0);
        if (mode == SILENT) return;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && mode == ACK) begin
                dev_dat_low = 1'b1;
                repeat (4) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k == poke_k) begin
                call = 1'b1;
                data = poke_d;
                @(negedge clk);
                call = 1'b0;
            end
            if (k == reset_k) begin
                dev_clk_low = 1'b0;
                rst_n = 1'b0;
                #1;
                check("reset_pins", 32'({ps2_clk, ps2_dat}), 32'h3);
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_done", 32'(done), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            dev_clk_low = 1'b0;
            if (k <= 10) cap_frame[k-1] = ps2_dat;
            if (k == 11) dev_dat_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input int mode, input int poke_k, input int reset_k);
        exp_t e;
        int   n;
        @(negedge clk);
        call = 1'b1;
        data = d;
        @(negedge clk);
        call = 1'b0;
        if (reset_k == 0) begin
            e.d = d;
            e.err = (mode != ACK);
            e.has_frame = (mode != SILENT);
            expq.push_back(e);
        end
        device(mode, poke_k, ~d, reset_k);
        n = 0;
        while (busy !== 1'b0 && n < 3 * TO) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("busy_timeout", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Held in reset with iCall pulsed: nothing may move
        call = 1'b1;
        data = 8'hFF;
        repeat (5) @(negedge clk);
        check("rst_pins", 32'({ps2_clk, ps2_dat}), 32'h3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        call = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        xfer(8'hF4, ACK, 0, 0);
        xfer(8'hFF, ACK, 0, 0);
        xfer(8'hED, ACK, 0, 0);
        xfer(8'h5A, NOACK, 0, 0);
        xfer(8'h3C, SILENT, 0, 0);
        xfer(8'hF4, ACK, 0, 0);
        xfer(8'hA5, ACK, 5, 0);
        xfer(8'h81, ACK, 0, 6);
        check("post_reset_err", 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            xfer(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? NOACK : ACK, 0, 0);
        end
        repeat (10) @(negedge clk);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
